fetch_unit: RTL and testbench

- Instruction fetch stage of the single-issue core; sits directly upstream of the decoder.
- Owns the PC register and issues instruction-memory requests.
- Holds each fetched instruction word stable on the decoder's code input until the instruction retires.
- Computes the next PC from the decoder's pc_sel, the branch outcome and the jump/branch targets.

---
 rtl/fetch_unit_pkg.sv | 10 +
 rtl/pc_mux_pkg.sv | 7 +
 rtl/next_pc_mux.sv | 29 ++
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Fetch-stage state encodings and the instruction word shown before the first fetch.
package fetch_unit_pkg;
   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HOLD  = 2'd1,
      S_FAULT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
endpackage

// File: rtl/pc_mux_pkg.sv
// Shared next-PC select encodings, produced by the decoder and consumed by fetch.
package pc_mux_pkg;
   localparam int SEL_PC_WIDTH = 2;
   localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_ADD4 = 2'd0;
   localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JAL  = 2'd1;
   localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JALR = 2'd2;
endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection: JALR > JAL > taken branch > sequential.
module next_pc_mux
   import pc_mux_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]         pc_i,
   input  logic [SEL_PC_WIDTH-1:0] pc_sel_i,
   input  logic                    br_taken_i,
   input  logic [XLEN-1:0]         jal_target_i,
   input  logic [XLEN-1:0]         jalr_target_i,
   input  logic [XLEN-1:0]         br_target_i,
   output logic [XLEN-1:0]         next_pc_o,
   output logic                    misaligned_o
);
   localparam logic [XLEN-1:0] FOUR = {{(XLEN-3){1'b0}}, 3'd4};

   always_comb begin
      next_pc_o = pc_i + FOUR;
      case (pc_sel_i)
         SEL_PC_JALR: next_pc_o = {jalr_target_i[XLEN-1:1], 1'b0};
         SEL_PC_JAL:  next_pc_o = jal_target_i;
         // ADD4 and any unknown encoding: only here does the branch outcome matter
         default: if (br_taken_i) next_pc_o = br_target_i;
      endcase
   end

   assign misaligned_o = |next_pc_o[1:0];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests imem, holds the word until retire.
module fetch_unit
   import pc_mux_pkg::*;
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    imem_req,
   output logic [XLEN-1:0]         imem_addr,
   input  logic                    imem_ack,
   input  logic [XLEN-1:0]         imem_rdata,
   output logic [XLEN-1:0]         code,
   output logic [XLEN-1:0]         pc,
   output logic                    code_valid,
   input  logic                    retire,
   input  logic [SEL_PC_WIDTH-1:0] pc_sel,
   input  logic [XLEN-1:0]         jal_target,
   input  logic [XLEN-1:0]         jalr_target,
   input  logic                    br_taken,
   input  logic [XLEN-1:0]         br_target,
   output logic                    fault
);
   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] code_q, code_d;
   logic            req_q;
   logic [XLEN-1:0] next_pc;
   logic            misaligned;

   next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
      .pc_i          (pc_q),
      .pc_sel_i      (pc_sel),
      .br_taken_i    (br_taken),
      .jal_target_i  (jal_target),
      .jalr_target_i (jalr_target),
      .br_target_i   (br_target),
      .next_pc_o     (next_pc),
      .misaligned_o  (misaligned)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      code_d  = code_q;
      case (state_q)
         S_REQ: begin
            if (imem_ack) begin
               code_d  = imem_rdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            // A misaligned target is still loaded so the faulting address is visible
            if (retire) begin
               pc_d    = next_pc;
               state_d = misaligned ? S_FAULT : S_REQ;
            end
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
   end

   // req is registered from the next state so it stays low throughout reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC[XLEN-1:0];
         code_q  <= NOP_INSN[XLEN-1:0];
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         code_q  <= code_d;
         req_q   <= (state_d == S_REQ);
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign code       = code_q;
   assign pc         = pc_q;
   assign code_valid = (state_q == S_HOLD);
   assign fault      = (state_q == S_FAULT);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch addresses and words, a monitor checks them.
module tb_fetch_unit;
   import pc_mux_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] code, pc;
   logic        code_valid;
   logic        retire = 1'b0;
   logic [1:0]  pc_sel = SEL_PC_ADD4;
   logic [31:0] jal_target = '0, jalr_target = '0, br_target = '0;
   logic        br_taken = 1'b0;
   logic        fault;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_req[$];
   logic [63:0] exp_code[$];
   logic        cv_prev = 1'b0;

   fetch_unit #(.RESET_PC(32'h0), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .code(code), .pc(pc),
      .code_valid(code_valid), .retire(retire), .pc_sel(pc_sel),
      .jal_target(jal_target), .jalr_target(jalr_target), .br_taken(br_taken),
      .br_target(br_target), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: request address checked on the ack cycle, code/pc on code_valid rise
   always @(negedge clk) begin
      if (rst_n && imem_req && imem_ack) begin
         if (exp_req.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: addr %h with nothing expected", imem_addr);
         end else chk("req_addr", imem_addr, exp_req.pop_front());
      end
      if (code_valid && !cv_prev) begin
         if (exp_code.size() == 0) begin
            checks++; errors++;
            $display("FAIL code_unexpected: code %h pc %h with nothing expected", code, pc);
         end else begin
            logic [63:0] e;
            e = exp_code.pop_front();
            chk("code_word", code, e[63:32]);
            chk("code_pc", pc, e[31:0]);
         end
      end
      cv_prev = code_valid;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic serve(input logic [31:0] addr, input logic [31:0] data, input int stall);
      int t = 0;
      while (!imem_req && t < 50) begin cyc(1); t++; end
      if (!imem_req) begin
         checks++; errors++;
         $display("FAIL req_timeout: no request for %h", addr);
         return;
      end
      exp_req.push_back(addr);
      for (int i = 0; i < stall; i++) begin
         cyc(1);
         chk("stall_req", {31'b0, imem_req}, 32'd1);
         chk("stall_addr", imem_addr, addr);
      end
      imem_ack = 1'b1; imem_rdata = data;
      exp_code.push_back({data, addr});
      cyc(1);
      imem_ack = 1'b0; imem_rdata = 32'hA5A5_A5A5;
      chk("cv_after_ack", {31'b0, code_valid}, 32'd1);
   endtask

   task automatic do_retire(input logic [1:0] sel, input logic bt, input logic [31:0] jt,
                            input logic [31:0] jrt, input logic [31:0] bto);
      pc_sel = sel; br_taken = bt; jal_target = jt; jalr_target = jrt; br_target = bto;
      retire = 1'b1;
      cyc(1);
      retire = 1'b0; br_taken = 1'b0; pc_sel = SEL_PC_ADD4;
      chk("cv_drop", {31'b0, code_valid}, 32'd0);
   endtask

   task automatic reset_release();
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_cv", {31'b0, code_valid}, 32'd0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_code", code, 32'h0000_0013);
      reset_release();
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      serve(32'h0, 32'h0050_0093, 1);

      // Hold with no retire, spurious ack in the middle
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
         cyc(1);
         imem_ack = 1'b0;
         chk("hold_code", code, 32'h0050_0093);
         chk("hold_pc", pc, 32'h0);
      end
      chk("hold_cv", {31'b0, code_valid}, 32'd1);

      // JAL beats a taken branch; long stall on the next fetch
      do_retire(SEL_PC_JAL, 1'b1, 32'h10, 32'h0, 32'h80);
      serve(32'h10, 32'h1111_0013, 10);
      do_retire(SEL_PC_ADD4, 1'b0, 32'h0, 32'h0, 32'h0);
      serve(32'h14, 32'h2222_0013, 0);
      // Unknown select behaves as ADD4
      do_retire(2'd3, 1'b0, 32'h300, 32'h400, 32'h500);
      serve(32'h18, 32'h3333_0013, 2);
      do_retire(SEL_PC_JALR, 1'b1, 32'h600, 32'h205, 32'h700);
      serve(32'h204, 32'h4444_0013, 0);
      do_retire(SEL_PC_JAL, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
      serve(32'hFFFF_FFFC, 32'h5555_0013, 1);
      do_retire(SEL_PC_ADD4, 1'b0, 32'h0, 32'h0, 32'h0);
      serve(32'h0, 32'h6666_0013, 0);
      do_retire(SEL_PC_ADD4, 1'b1, 32'h0, 32'h0, 32'h40);
      serve(32'h40, 32'h7777_0013, 0);

      // Asynchronous reset between edges while holding
      cyc(1);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_cv", {31'b0, code_valid}, 32'd0);
      chk("areset_req", {31'b0, imem_req}, 32'd0);
      chk("areset_pc", pc, 32'h0);
      chk("areset_code", code, 32'h0000_0013);
      reset_release();
      serve(32'h0, 32'h0010_0113, 0);

      // Misaligned taken branch
      do_retire(SEL_PC_ADD4, 1'b1, 32'h0, 32'h0, 32'h42);
      chk("fault_flag", {31'b0, fault}, 32'd1);
      chk("fault_pc", pc, 32'h42);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) imem_ack = 1'b1;
         cyc(1);
         imem_ack = 1'b0;
         chk("fault_noreq", {31'b0, imem_req}, 32'd0);
      end
      chk("fault_sticky", {31'b0, fault}, 32'd1);
      chk("fault_cv", {31'b0, code_valid}, 32'd0);

      // JALR to 0x203 clears bit 0 but bit 1 still faults
      rst_n = 1'b0;
      #1 chk("rst2_fault", {31'b0, fault}, 32'd0);
      reset_release();
      serve(32'h0, 32'h0020_0193, 0);
      do_retire(SEL_PC_JALR, 1'b0, 32'h0, 32'h203, 32'h0);
      chk("jalr_fault", {31'b0, fault}, 32'd1);
      chk("jalr_fault_pc", pc, 32'h202);
      cyc(3);
      chk("jalr_noreq", {31'b0, imem_req}, 32'd0);

      chk("req_drained", exp_req.size(), 32'd0);
      chk("code_drained", exp_code.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1);
   end
endmodule
